// File: rtl/icache_ctrl_if.sv
// Fetch-side and refill-side signals of the instruction cache controller.
// The ICACHE_STATS_EN macro adds the hit_count/miss_count statistics outputs.
interface icache_ctrl_if;
   logic [31:0] pc_in;
   logic        inv;
   logic [31:0] instr;
   logic        valid;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   modport slave  (input  pc_in, inv, mem_rdata, mem_ack,
                   output instr, valid, mem_req, mem_addr, hit_count, miss_count);
   modport master (output pc_in, inv, mem_rdata, mem_ack,
                   input  instr, valid, mem_req, mem_addr, hit_count, miss_count);
`else
   modport slave  (input  pc_in, inv, mem_rdata, mem_ack,
                   output instr, valid, mem_req, mem_addr);
   modport master (output pc_in, inv, mem_rdata, mem_ack,
                   input  instr, valid, mem_req, mem_addr);
`endif
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache controller with a single refill port.
// Optional ICACHE_STATS_EN macro enables saturating hit/miss counters.
module icache_ctrl #(
   parameter int unsigned LINES = 16
) (
   input logic          clk,
   input logic          rst,
   icache_ctrl_if.slave bus
);
   localparam int unsigned IDX  = $clog2(LINES);
   localparam int unsigned TAGW = 30 - IDX;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t            state, state_nx;
   logic [LINES-1:0]  line_valid;
   logic [TAGW-1:0]   tag_mem  [LINES];
   logic [31:0]       data_mem [LINES];
   logic [31:2]       miss_pc, miss_pc_nx;

   logic [IDX-1:0]    idx, fill_idx;
   logic [TAGW-1:0]   tag;
   logic              hit;
   logic              valid_nx, req_nx, fill_en, hit_ev, miss_ev;
   logic [31:0]       instr_nx;
   logic              unused_pc_lsb;

   assign idx           = bus.pc_in[IDX+1:2];
   assign tag           = bus.pc_in[31:IDX+2];
   assign fill_idx      = miss_pc[IDX+1:2];
   assign hit           = line_valid[idx] && (tag_mem[idx] == tag);
   assign bus.mem_addr  = {miss_pc, 2'b00};
   assign unused_pc_lsb = ^bus.pc_in[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      valid_nx   = 1'b0;
      instr_nx   = bus.instr;
      req_nx     = bus.mem_req;
      miss_pc_nx = miss_pc;
      fill_en    = 1'b0;
      hit_ev     = 1'b0;
      miss_ev    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!bus.inv) begin
               if (hit) begin
                  valid_nx = 1'b1;
                  instr_nx = data_mem[idx];
                  hit_ev   = 1'b1;
               end else begin
                  miss_pc_nx = bus.pc_in[31:2];
                  req_nx     = 1'b1;
                  state_nx   = REFILL;
                  miss_ev    = 1'b1;
               end
            end
         end
         REFILL: begin
            if (bus.mem_ack) begin
               state_nx = IDLE;
               req_nx   = 1'b0;
               // A concurrent invalidate discards the refill; a moved pc still fills the line.
               if (!bus.inv) begin
                  fill_en = 1'b1;
                  if (bus.pc_in[31:2] == miss_pc) begin
                     valid_nx = 1'b1;
                     instr_nx = bus.mem_rdata;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.valid   <= 1'b0;
         bus.instr   <= NOP;
         bus.mem_req <= 1'b0;
         miss_pc     <= '0;
      end else begin
         bus.valid   <= valid_nx;
         bus.instr   <= instr_nx;
         bus.mem_req <= req_nx;
         miss_pc     <= miss_pc_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          line_valid <= '0;
      else if (bus.inv) line_valid <= '0;
      else if (fill_en) line_valid[fill_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_mem[fill_idx]  <= miss_pc[31:IDX+2];
         data_mem[fill_idx] <= bus.mem_rdata;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.hit_count  <= '0;
         bus.miss_count <= '0;
      end else begin
         if (hit_ev && bus.hit_count != '1)   bus.hit_count  <= bus.hit_count + 32'd1;
         if (miss_ev && bus.miss_count != '1) bus.miss_count <= bus.miss_count + 32'd1;
      end
   end
`else
   logic unused_ev;
   assign unused_ev = hit_ev ^ miss_ev;
`endif

endmodule
